gate_bist_ctrl: RTL and testbench
=================================

# gate_bist_ctrl

Built-in self-test sequencer for the library's small combinational gates. It drives every input combination into one gate under test, waits a programmable settle time, and compares the gate output against an expected truth table. It reports pass/fail, the first failing vector and an error count. It sits beside the gate instance and replaces hand-written `#delay` stimulus with a synthesizable, cycle-accurate check.

## Interface
Parameters:
- `N_IN`, 2: number of gate inputs; sweeps 2^N_IN vectors (1..4 supported).
- `SETTLE_CYC`, 2: cycles the vector is held before the output is sampled (>= 1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a sweep.
- `exp_tt`  in  2^N_IN: expected truth table; bit i = expected output for input vector i (2-input AND = 4'b1000).
- `dut_y`  in  1: output of the gate under test.
- `dut_in`  out  N_IN: registered input vector driven to the gate.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: one-cycle pulse at end of sweep.
- `pass`  out  1: result of the last completed sweep; valid from `done` until the next `start`.
- `fail_vec`  out  N_IN: first mismatching vector of the last sweep; 0 if none.
- `err_cnt`  out  N_IN+1: number of mismatching vectors in the last sweep.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: `start`=1 captures `exp_tt` into an internal register. It also clears `dut_in`, `err_cnt` and `fail_vec`, loads the settle counter with SETTLE_CYC-1, and moves to SETTLE. `busy` is set.
- SETTLE: the counter decrements each cycle. At 0 the FSM moves to CHECK. `dut_in` is held.
- CHECK: compares `dut_y` with the captured `exp_tt[dut_in]`.
  - On mismatch: increment `err_cnt`. If this is the first error, `fail_vec` <= `dut_in`.
  - If `dut_in` is the last vector (all ones), go to DONE.
  - Otherwise increment `dut_in`, reload the counter, and go to SETTLE.
- DONE: `done`=1 for one cycle. `pass` <= (`err_cnt`==0, including a mismatch recorded in the final CHECK). `busy` clears. Next state is IDLE.
- `start` is ignored outside IDLE, including in the DONE cycle.
- `exp_tt` changes after capture have no effect on the running sweep.
- `dut_in` retains the last vector after the sweep.
- `err_cnt` never overflows: the maximum is 2^N_IN, which fits in N_IN+1 bits.
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `fail_vec`=0, `err_cnt`=0, state=IDLE.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronous). No `done` pulse is produced.

## Timing
- `start` is sampled at edge k. `busy` is high from k+1.
- Each vector takes SETTLE_CYC + 1 cycles.
- `done` is high in cycle k + 1 + 2^N_IN·(SETTLE_CYC+1). Defaults: k+13.
- `dut_y` is sampled at the CHECK edge, so the gate has SETTLE_CYC+1 cycles from the `dut_in` change.
- Back-to-back sweeps: the earliest next `start` is the cycle after `done`.

## Configuration
- `GATE_BIST_STOP_ON_FAIL_EN` defined: on the first CHECK mismatch the FSM goes directly to DONE. `err_cnt`=1, `pass`=0, and `fail_vec` is the failing vector.
- Not defined: all vectors are always swept and every mismatch is counted.

## Structure
- Package `gate_bist_pkg`:
  - state typedef `gate_bist_state_t` with ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE.
  - constant `GATE_BIST_MAX_IN` = 4.
  - truth-table constants `TT_AND2` = 4'b1000, `TT_OR2` = 4'b1110, `TT_XOR2` = 4'b0110.
- Sub-module `gate_bist_settle_timer`: loadable down-counter with a zero flag, sized $clog2(SETTLE_CYC)+1.
- FSM, compare and result registers live in `gate_bist_ctrl`.

## Test plan
Default parameters; bench instantiates the 2-input gate as the DUT.
- Real AND gate, `exp_tt`=4'b1000, `start` at cycle 0 -> `dut_in` steps 00,01,10,11; `done` at cycle 13; `pass`=1, `err_cnt`=0, `fail_vec`=00.
- `dut_y` tied 0, `exp_tt`=4'b1000 -> `pass`=0, `err_cnt`=1, `fail_vec`=11.
- `dut_y` tied 1, `exp_tt`=4'b1000 -> `err_cnt`=3, `fail_vec`=00. With `GATE_BIST_STOP_ON_FAIL_EN`: `done` at cycle 4, `err_cnt`=1.
- `start` pulsed again at cycles 5 and 13 during a sweep -> ignored; exactly one `done`; `exp_tt` changed at cycle 3 -> result unchanged.
- `rst_n` low at cycle 7 -> all outputs 0 asynchronously, no `done`. A fresh `start` after release -> normal 13-cycle sweep.
- OR gate with `exp_tt`=4'b1110 -> `pass`=1. Same gate with `exp_tt`=4'b1000 -> `err_cnt`=2, `fail_vec`=01.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// -----------------------------------------------------------------------------
// gate_bist_pkg
// Shared types and constants for the gate built-in self-test sequencer.
//   gate_bist_state_t : sequencer FSM state encoding
//   GATE_BIST_MAX_IN  : widest gate the sequencer is intended for
//   TT_AND2/OR2/XOR2  : expected truth tables of the common 2-input gates;
//                       bit i is the expected output for input vector i
//   gate_bist_num_vec : number of vectors swept for a given input count
// -----------------------------------------------------------------------------
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } gate_bist_state_t;

    localparam int GATE_BIST_MAX_IN = 4;

    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

    function automatic int gate_bist_num_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_bist_settle_timer.sv
// -----------------------------------------------------------------------------
// gate_bist_settle_timer
// Loadable down-counter that times how long a vector is held on the gate
// before its output is sampled.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with SETTLE_CYC-1 (has priority)
//   dec        : decrement by one; the counter stops at zero
//   zero       : counter is at zero
// -----------------------------------------------------------------------------
module gate_bist_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
// Built-in self-test sequencer for a small combinational gate. Sweeps every
// input vector, holds each for SETTLE_CYC cycles, then compares the gate
// output against a truth table captured at start.
//
// Parameters:
//   N_IN       : gate input count (1..4), 2^N_IN vectors are swept
//   SETTLE_CYC : cycles a vector is held before the output is sampled (>= 1)
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : one-cycle sweep request, honoured only in IDLE
//   exp_tt     : expected truth table, bit i = output for vector i
//   dut_y      : output of the gate under test
//   dut_in     : registered vector driven to the gate
//   busy       : sweep in progress (SETTLE/CHECK)
//   done       : one-cycle end-of-sweep pulse
//   pass       : last sweep had no mismatch; valid from done to next start
//   fail_vec   : first mismatching vector of the last sweep, 0 if none
//   err_cnt    : number of mismatching vectors of the last sweep
//   fsm_state  : current sequencer state, for observation
//
// Build option:
//   GATE_BIST_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//                               sweep immediately (err_cnt = 1).
//
// Handshake: start is a level sampled on the rising edge while the FSM is in
// IDLE; there is no back-pressure, and a start seen in any other state
// (including the DONE cycle) is dropped.
// -----------------------------------------------------------------------------
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   exp_tt,
    input  logic                   dut_y,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN-1:0]        fail_vec,
    output logic [N_IN:0]          err_cnt,
    output gate_bist_state_t       fsm_state
);

    localparam int NUM_VEC = 1 << N_IN;

    gate_bist_state_t state;
    gate_bist_state_t state_next;

    logic [NUM_VEC-1:0] tt_q;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_zero;
    logic               mismatch;
    logic               last_vec;
    logic               stop_now;
    logic [N_IN:0]      err_cnt_next;

    // Compare the sampled gate output against the captured truth table.
    assign mismatch     = (dut_y != tt_q[dut_in]);
    assign last_vec     = &dut_in;
    assign err_cnt_next = err_cnt + (N_IN+1)'(mismatch);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Settle timer
    // ---------------------------------------------------------------
    gate_bist_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .dec   (timer_dec),
        .zero  (timer_zero)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (last_vec || stop_now) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_load = start;
            end
            ST_SETTLE: begin
                busy      = 1'b1;
                timer_dec = 1'b1;
            end
            ST_CHECK: begin
                busy       = 1'b1;
                // Reload only when another vector follows.
                timer_load = !(last_vec || stop_now);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign fsm_state = state;

    // ---------------------------------------------------------------
    // Vector, truth-table capture and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q     <= '0;
            dut_in   <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tt_q     <= exp_tt;
                        dut_in   <= '0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    err_cnt <= err_cnt_next;
                    if (mismatch && (err_cnt == '0)) begin
                        fail_vec <= dut_in;
                    end
                    // pass is settled on the way into DONE so that it already
                    // reflects a mismatch found in this final check while
                    // done is high.
                    if (last_vec || stop_now) begin
                        pass <= (err_cnt_next == '0);
                    end else begin
                        dut_in <= dut_in + N_IN'(1);
                    end
                end
                default: begin
                    dut_in <= dut_in;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_ctrl
// Directed bench for gate_bist_ctrl with default parameters. A behavioural
// 2-input gate (AND, tied 0, tied 1, OR) sits on dut_in/dut_y. Each sweep's
// expected result is computed from the gate model and truth table and queued
// when start is driven; it is popped and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    localparam int N_IN       = 2;
    localparam int SETTLE_CYC = 2;
    localparam int RW         = 1 + (N_IN + 1) + N_IN;

    localparam int M_AND  = 0;
    localparam int M_TIE0 = 1;
    localparam int M_TIE1 = 2;
    localparam int M_OR   = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       exp_tt = 4'b0000;
    logic             dut_y;
    logic [N_IN-1:0]  dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN-1:0]  fail_vec;
    logic [N_IN:0]    err_cnt;
    gate_bist_state_t fsm_state;

    int gate_mode = M_AND;
    int n_assert  = 0;
    int n_fail    = 0;

    logic [RW-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- gate under test ----------------
    function automatic logic gate_fn(input int m, input logic [1:0] v);
        case (m)
            M_AND:   return v[1] & v[0];
            M_TIE0:  return 1'b0;
            M_TIE1:  return 1'b1;
            default: return v[1] | v[0];
        endcase
    endfunction

    always_comb dut_y = gate_fn(gate_mode, dut_in);

    gate_bist_ctrl #(
        .N_IN       (N_IN),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .exp_tt    (exp_tt),
        .dut_y     (dut_y),
        .dut_in    (dut_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_vec  (fail_vec),
        .err_cnt   (err_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one full sweep ----------------
    // glitch: change exp_tt at cycle 3 and pulse start at cycles 5 and 13.
    task automatic run_sweep(input logic [3:0] tt, input int mode, input bit glitch, input string tag);
        int            err;
        int            fv;
        int            done_cyc;
        int            cyc;
        int            extra;
        bit            got;
        logic [RW-1:0] e;

        err = 0;
        fv  = 0;
        for (int v = 0; v < 4; v++) begin
            if (gate_fn(mode, 2'(v)) != tt[v]) begin
                if (err == 0) fv = v;
                err++;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        done_cyc = 13;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        if (err > 0) done_cyc = 3 * (fv + 1) + 1;
`endif
        exp_q.push_back({(err == 0), 3'(err), 2'(fv)});

        gate_mode = mode;
        @(negedge clk);
        exp_tt = tt;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_k1"}, 32'(busy), 32'd1);

        got = 1'b0;
        while (cyc <= 40) begin
            if (glitch) begin
                if (cyc == 3)                start  = 1'b0;
                if (cyc == 3)                exp_tt = ~tt;
                if (cyc == 5 || cyc == 13)   start  = 1'b1;
                if (cyc == 6)                start  = 1'b0;
            end
            if ((cyc % 3 == 1) && (cyc < done_cyc)) begin
                check({tag, "_dut_in"}, 32'(dut_in), 32'((cyc - 1) / 3));
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end

        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(done_cyc));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pass"},     32'(pass),     32'(e[RW-1]));
            check({tag, "_err_cnt"},  32'(err_cnt),  32'(e[N_IN +: N_IN+1]));
            check({tag, "_fail_vec"}, 32'(fail_vec), 32'(e[N_IN-1:0]));
        end

        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_state"}, 32'(fsm_state), 32'(ST_IDLE));

        if (glitch) begin
            extra = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
        exp_tt = 4'b0000;
    endtask

    // ---------------- driver: reset in the middle of a sweep ----------------
    task automatic reset_mid_sweep();
        int dones;
        gate_mode = M_AND;
        dones     = 0;
        @(negedge clk);
        exp_tt = TT_AND2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 7; cyc++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dut_in",   32'(dut_in),    32'd0);
        check("rst_mid_busy",     32'(busy),      32'd0);
        check("rst_mid_done",     32'(done),      32'd0);
        check("rst_mid_pass",     32'(pass),      32'd0);
        check("rst_mid_fail_vec", 32'(fail_vec),  32'd0);
        check("rst_mid_err_cnt",  32'(err_cnt),   32'd0);
        check("rst_mid_state",    32'(fsm_state), 32'(ST_IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_mid_no_done", 32'(dones), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dut_in",   32'(dut_in),    32'd0);
        check("reset_busy",     32'(busy),      32'd0);
        check("reset_done",     32'(done),      32'd0);
        check("reset_pass",     32'(pass),      32'd0);
        check("reset_fail_vec", 32'(fail_vec),  32'd0);
        check("reset_err_cnt",  32'(err_cnt),   32'd0);
        check("reset_state",    32'(fsm_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(TT_AND2, M_AND,  1'b0, "and_pass");
        run_sweep(TT_AND2, M_TIE0, 1'b0, "tie0");
        run_sweep(TT_AND2, M_TIE1, 1'b0, "tie1");
        run_sweep(TT_AND2, M_AND,  1'b1, "glitch");
        reset_mid_sweep();
        run_sweep(TT_AND2, M_AND,  1'b0, "after_rst");
        run_sweep(TT_OR2,  M_OR,   1'b0, "or_pass");
        run_sweep(TT_AND2, M_OR,   1'b0, "or_vs_and");
        run_sweep(TT_XOR2, M_AND,  1'b0, "and_vs_xor");
        for (int i = 0; i < 4; i++) begin
            run_sweep(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0, "rand");
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
